uar_rx_param: RTL and testbench

Parametrised next-generation RS232 receiver for the UART/AXI interface path. It adds configurable data width, programmable parity, one or two stop bits and 3-sample majority voting. It reports framing, parity, overrun and break errors per word. Received words leave through a valid/ready holding register, so the AXI-side bridge can back-pressure without losing a word silently.

---
 rtl/uar_pkg.sv | 26 ++
 rtl/uar_rx_vote.sv | 30 +++
 rtl/uar_synchro.sv | 24 ++
 rtl/uar_rx_param.sv | 200 ++++++++++++++++++++
 tb/tb_uar_rx_param.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uar_pkg.sv
// Shared types for the parametrised RS232 receiver.
// Parity modes, receiver FSM states and per-word flag bundle.
package uar_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRKWAIT
  } rx_state_t;

  typedef struct packed {
    logic parityErr;
    logic frameErr;
    logic overrun;
    logic breakDet;
  } rx_flags_t;

endpackage

// File: rtl/uar_rx_vote.sv
// Three-sample majority voter; the third sample is the live input,
// so the vote is ready on the same tick as the last strobe.
module uar_rx_vote (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  input  logic i_s0,
  input  logic i_s1,
  input  logic i_s2,
  output logic o_dec,
  output logic o_bit
);

  logic r_a;
  logic r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= 1'b0;
      r_b <= 1'b0;
    end else begin
      if (i_s0) r_a <= i_rx;
      if (i_s1) r_b <= i_rx;
    end
  end

  assign o_dec = i_s2;
  assign o_bit = (r_a & r_b) | (r_a & i_rx) | (r_b & i_rx);

endmodule

// File: rtl/uar_synchro.sv
// Two-flop synchroniser for the asynchronous RS232 line.
// Resets to the line idle level so reset never looks like a start edge.
module uar_synchro #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/uar_rx_param.sv
// Parametrised RS232 receiver: majority voting, parity, 1/2 stop bits,
// break detection and a valid/ready holding register with overrun.
module uar_rx_param
  import uar_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              tick,
  input  logic              RxEn,
  input  logic              Rx,
  input  logic [3:0]        nBits,
  input  logic [1:0]        parityMode,
  input  logic              twoStop,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  input  logic              RxReady,
  output logic              parityErr,
  output logic              frameErr,
  output logic              overrun,
  output logic              breakDet
);

  // Counter restarts at each bit decision, so it never exceeds OVS+1.
  localparam int CNT_W = $clog2(OVS * 2);
  localparam logic [CNT_W-1:0] C_MID0 = CNT_W'(OVS / 2);
  localparam logic [CNT_W-1:0] C_MIDN = CNT_W'(OVS - 1);

  logic              w_rx;
  logic              w_s0;
  logic              w_s1;
  logic              w_s2;
  logic              w_dec;
  logic              w_bit;
  logic              w_act;
  logic              w_fall;
  logic              w_haspar;
  logic [3:0]        w_nb;
  logic [CNT_W-1:0]  w_tn;
  logic [CNT_W-1:0]  w_mid;

  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_nbits;
  logic [3:0]        r_bit;
  logic [1:0]        r_pm;
  logic              r_two;
  logic              r_prev;
  logic              r_par;
  logic              r_any1;
  logic              r_perr;
  logic              r_ferr;
  logic              r_brk;
  logic              r_done;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_hold;
  logic              r_valid;
  rx_flags_t         r_flags;

  uar_synchro u_sync (
    .clk   (Clk),
    .rst_n (Rst_n),
    .i_d   (Rx),
    .o_q   (w_rx)
  );

  uar_rx_vote u_vote (
    .clk   (Clk),
    .rst_n (Rst_n),
    .i_rx  (w_rx),
    .i_s0  (w_s0),
    .i_s1  (w_s1),
    .i_s2  (w_s2),
    .o_dec (w_dec),
    .o_bit (w_bit)
  );

  always_comb begin
    w_nb = nBits;
    if (nBits < 4'd5 || int'(nBits) > DATA_W) w_nb = 4'(DATA_W);
  end

  assign w_act = r_state inside {ST_START, ST_DATA, ST_PARITY,
                                 ST_STOP1, ST_STOP2};
  assign w_mid = (r_state == ST_START) ? C_MID0 : C_MIDN;
  assign w_tn  = r_cnt + CNT_W'(1);
  assign w_s0  = tick & w_act & (w_tn == w_mid - CNT_W'(1));
  assign w_s1  = tick & w_act & (w_tn == w_mid);
  assign w_s2  = tick & w_act & (w_tn == w_mid + CNT_W'(1));
  assign w_fall = r_prev & ~w_rx & RxEn & (r_state == ST_IDLE);
  assign w_haspar = (r_pm == PAR_EVEN) | (r_pm == PAR_ODD);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_nbits <= '0;
      r_bit   <= '0;
      r_pm    <= PAR_NONE;
      r_two   <= 1'b0;
      r_prev  <= 1'b1;
      r_par   <= 1'b0;
      r_any1  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_prev <= w_rx;
      r_done <= 1'b0;
      if (tick && w_act) begin
        if (w_dec) r_cnt <= '0;
        else if (r_cnt != '1) r_cnt <= w_tn;
      end
      unique case (r_state)
        ST_IDLE: if (w_fall) begin
          r_state <= ST_START;
          r_cnt   <= '0;
          r_nbits <= w_nb;
          r_pm    <= parityMode;
          r_two   <= twoStop;
          r_bit   <= '0;
          r_data  <= '0;
          r_par   <= 1'b0;
          r_any1  <= 1'b0;
          r_perr  <= 1'b0;
          r_ferr  <= 1'b0;
          r_brk   <= 1'b0;
        end
        ST_START: if (w_dec) begin
          r_state <= w_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (w_dec) begin
          r_data <= r_data | (DATA_W'(w_bit) << r_bit);
          r_par  <= r_par ^ w_bit;
          r_any1 <= r_any1 | w_bit;
          r_bit  <= r_bit + 4'd1;
          if (r_bit == r_nbits - 4'd1)
            r_state <= w_haspar ? ST_PARITY : ST_STOP1;
        end
        ST_PARITY: if (w_dec) begin
          r_perr  <= r_par ^ w_bit ^ (r_pm == PAR_ODD);
          r_any1  <= r_any1 | w_bit;
          r_state <= ST_STOP1;
        end
        ST_STOP1: if (w_dec) begin
          r_ferr <= ~w_bit;
          if (~w_bit & ~r_any1) begin
            r_brk   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_BRKWAIT;
          end else if (r_two) begin
            r_state <= ST_STOP2;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_STOP2: if (w_dec) begin
          r_ferr  <= r_ferr | ~w_bit;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_BRKWAIT: if (w_rx) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A word arriving while the held one is unaccepted is dropped.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_flags <= '0;
    end else if (r_done) begin
      if (!r_valid || RxReady) begin
        r_hold  <= r_data;
        r_valid <= 1'b1;
        r_flags <= {r_perr, r_ferr, 1'b0, r_brk};
      end else begin
        r_flags.overrun <= 1'b1;
      end
    end else if (r_valid && RxReady) begin
      r_valid <= 1'b0;
      r_flags <= '0;
    end
  end

  assign RxData    = r_hold;
  assign RxValid   = r_valid;
  assign parityErr = r_flags.parityErr;
  assign frameErr  = r_flags.frameErr;
  assign overrun   = r_flags.overrun;
  assign breakDet  = r_flags.breakDet;

endmodule

// File: tb/tb_uar_rx_param.sv
// Bench for uar_rx_param: directed and random frames scored
// against a frame-level reference model.
module tb_uar_rx_param;

  localparam int DW   = 8;
  localparam int OVS  = 16;
  localparam int TDIV = 4;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          RxEn = 1'b1;
  logic          Rx = 1'b1;
  logic [3:0]    nBits = 4'd8;
  logic [1:0]    parityMode = 2'd0;
  logic          twoStop = 1'b0;
  logic [DW-1:0] RxData;
  logic          RxValid;
  logic          RxReady = 1'b1;
  logic          parityErr;
  logic          frameErr;
  logic          overrun;
  logic          breakDet;

  typedef struct {
    logic [7:0] d;
    logic pe;
    logic fe;
    logic ov;
    logic bk;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;
  int   cyc = 0;
  int   t_fall = 0;
  int   t_rise = 0;
  int   run_len = 0;
  int   last_len = 0;
  logic prev_v = 1'b0;

  uar_rx_param #(.DATA_W(DW), .OVS(OVS)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .tick       (tick),
    .RxEn       (RxEn),
    .Rx         (Rx),
    .nBits      (nBits),
    .parityMode (parityMode),
    .twoStop    (twoStop),
    .RxData     (RxData),
    .RxValid    (RxValid),
    .RxReady    (RxReady),
    .parityErr  (parityErr),
    .frameErr   (frameErr),
    .overrun    (overrun),
    .breakDet   (breakDet)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    forever begin
      repeat (TDIV - 1) @(posedge Clk);
      #1 tick = 1'b1;
      @(posedge Clk);
      #1 tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int eff_n(input logic [3:0] nbc);
    return (nbc < 5 || int'(nbc) > DW) ? DW : int'(nbc);
  endfunction

  function automatic exp_t model(input logic [3:0] nbc,
                                 input logic [7:0] d,
                                 input logic [1:0] pm,
                                 input logic pb, s1, s2, two);
    exp_t e;
    int   n;
    logic hp;
    n    = eff_n(nbc);
    e.d  = d & 8'((1 << n) - 1);
    hp   = (pm == 2'd1) || (pm == 2'd2);
    e.pe = hp && ((^e.d ^ pb) != (pm == 2'd2));
    e.fe = !s1 || (two && !s2);
    e.bk = (e.d == 8'd0) && (!hp || !pb) && !s1;
    e.ov = 1'b0;
    return e;
  endfunction

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge Clk);
      if (tick) c++;
    end
    #2;
  endtask

  task automatic bit_drv(input logic v, input int n);
    Rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n,
                            input logic [1:0] pm, input logic pb,
                            input logic s1, s2, two,
                            input int glitch);
    t_fall = cyc;
    bit_drv(1'b0, OVS);
    for (int i = 0; i < n; i++) begin
      if (i == glitch) begin
        bit_drv(d[i], OVS / 2);
        bit_drv(~d[i], 1);
        bit_drv(d[i], OVS / 2 - 1);
      end else begin
        bit_drv(d[i], OVS);
      end
    end
    if (pm == 2'd1 || pm == 2'd2) bit_drv(pb, OVS);
    bit_drv(s1, OVS);
    if (two) bit_drv(s2, OVS);
    bit_drv(1'b1, 2 * OVS);
  endtask

  task automatic run(input logic [3:0] nbc, input logic [7:0] d,
                     input logic [1:0] pm, input logic pb,
                     input logic s1, s2, two, input int glitch);
    nBits      = nbc;
    parityMode = pm;
    twoStop    = two;
    q.push_back(model(nbc, d, pm, pb, s1, s2, two));
    send_frame(d, eff_n(nbc), pm, pb, s1, s2, two, glitch);
  endtask

  always @(negedge Clk) begin
    if (RxValid && !prev_v) t_rise = cyc;
    if (RxValid) run_len = run_len + 1;
    else begin
      if (run_len > 0) last_len = run_len;
      run_len = 0;
    end
    prev_v = RxValid;
    if (Rst_n && RxValid && RxReady) begin
      n_acc++;
      if (q.size() == 0) begin
        chk("spurious_word", 1, 0);
      end else begin
        m_e = q.pop_front();
        chk("data", int'(RxData), int'(m_e.d));
        chk("parityErr", int'(parityErr), int'(m_e.pe));
        chk("frameErr", int'(frameErr), int'(m_e.fe));
        chk("overrun", int'(overrun), int'(m_e.ov));
        chk("breakDet", int'(breakDet), int'(m_e.bk));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n0;
    int   t;
    exp_t e;
    repeat (5) @(posedge Clk);
    #2;
    chk("rst_valid", int'(RxValid), 0);
    chk("rst_data", int'(RxData), 0);
    chk("rst_flags", int'({parityErr, frameErr, overrun, breakDet}), 0);
    Rst_n = 1'b1;
    bit_drv(1'b1, 2 * OVS);

    run(4'd8, 8'hA5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    chk("valid_width", last_len, 1);
    chk("latency_ok", int'(t_rise - t_fall >= 611 && t_rise - t_fall <= 616), 1);

    run(4'd8, 8'h37, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    run(4'd8, 8'h37, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, -1);

    n0 = n_acc;
    bit_drv(1'b0, 4);
    bit_drv(1'b1, 2 * OVS);
    chk("glitch_no_word", n_acc, n0);
    run(4'd8, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3);

    RxEn = 1'b0;
    n0 = n_acc;
    send_frame(8'h3C, 8, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    chk("rxen_off_no_word", n_acc, n0);
    RxEn = 1'b1;

    RxReady = 1'b0;
    e = model(4'd8, 8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    e.ov = 1'b1;
    q.push_back(e);
    send_frame(8'h11, 8, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    send_frame(8'h22, 8, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    chk("held_valid", int'(RxValid), 1);
    chk("held_data", int'(RxData), 'h11);
    chk("held_overrun", int'(overrun), 1);
    RxReady = 1'b1;
    wait_ticks(2);
    run(4'd8, 8'h33, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);

    nBits = 4'd8;
    parityMode = 2'd0;
    twoStop = 1'b0;
    q.push_back(model(4'd8, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    bit_drv(1'b0, 20 * OVS);
    bit_drv(1'b1, 2 * OVS);
    run(4'd8, 8'h5A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);

    run(4'd6, 8'h2B, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, -1);

    n0 = n_acc;
    nBits = 4'd8;
    bit_drv(1'b0, OVS);
    bit_drv(1'b1, OVS);
    bit_drv(1'b0, OVS);
    bit_drv(1'b1, OVS);
    Rst_n = 1'b0;
    Rx = 1'b1;
    repeat (5) @(posedge Clk);
    #2 Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    chk("midrst_valid", int'(RxValid), 0);
    chk("midrst_data", int'(RxData), 0);
    bit_drv(1'b1, 2 * OVS);
    chk("midrst_no_word", n_acc, n0);
    run(4'd8, 8'hC3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1);

    for (int i = 0; i < 20; i++) begin
      run(4'($urandom_range(0, 15)), 8'($urandom),
          2'($urandom_range(0, 3)), 1'($urandom),
          $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
          1'($urandom), -1);
    end

    t = 0;
    while (q.size() > 0 && t < 5000) begin
      @(posedge Clk);
      t++;
    end
    chk("drain_queue", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
